// File: rtl/code_lock_pkg.sv
// Shared types and constants for the serial code lock controller.
package code_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_FAIL    = 3'd2,
        ST_OPEN    = 3'd3,
        ST_LOCKOUT = 3'd4
    } lock_state_e;

    localparam int          FAIL_CNT_W        = 4;
    localparam logic [31:0] LOCK_DEFAULT_CODE = 32'd5938;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter; o_done marks the last cycle of a loaded interval.
module lock_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Loading N yields exactly N cycles before the owning state exits.
    assign o_done = (r_cnt == W'(1));

endmodule

// File: rtl/code_lock_fsm.sv
// Serial code lock: bit-serial compare, wrong-attempt lockout, timed relock, code change.
//   state      | meaning
//   ST_IDLE    | locked, waiting for a submitted code
//   ST_CHECK   | comparing one bit per cycle, MSB first
//   ST_FAIL    | one-cycle buzz, count the wrong attempt
//   ST_OPEN    | unlocked until relock, new submit or timeout
//   ST_LOCKOUT | too many wrong attempts, submits ignored
module code_lock_fsm
    import code_lock_pkg::*;
#(
    parameter int                CODE_W       = 16,
    parameter logic [CODE_W-1:0] DEFAULT_CODE = CODE_W'(LOCK_DEFAULT_CODE),
    parameter int                MAX_TRIES    = 3,
    parameter int                LOCKOUT_CYC  = 64,
    parameter int                OPEN_CYC     = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [CODE_W-1:0]     code_in,
    input  logic                  code_valid,
    input  logic                  prog_en,
    input  logic                  relock,
    output logic                  lock_n,
    output logic                  buzz,
    output logic                  busy,
    output logic                  locked_out,
    output logic [FAIL_CNT_W-1:0] fail_cnt,
    output logic [2:0]            state
);

    localparam int TMR_W = $clog2(max_int(OPEN_CYC, LOCKOUT_CYC)) + 1;
    localparam int IDX_W = $clog2(CODE_W);

    lock_state_e           r_state, w_next;
    logic [CODE_W-1:0]     r_code, r_shift;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_mismatch;
    logic [FAIL_CNT_W-1:0] r_fail_cnt;
    logic                  r_lock_n, r_buzz, r_busy, r_locked_out;
    logic                  w_mis_total, w_prog, w_tmr_load, w_tmr_done;
    logic [TMR_W-1:0]      w_tmr_val;

    assign w_mis_total = r_mismatch | (r_shift[CODE_W-1] ^ r_code[r_idx]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_prog = 1'b0;
        case (r_state)
            ST_IDLE:    if (code_valid) w_next = ST_CHECK;
            ST_CHECK:   if (r_idx == '0) w_next = w_mis_total ? ST_FAIL : ST_OPEN;
            ST_FAIL:    w_next = (r_fail_cnt >= FAIL_CNT_W'(MAX_TRIES)) ? ST_LOCKOUT : ST_IDLE;
            ST_OPEN: begin
                if (relock)                     w_next = ST_IDLE;
                else if (code_valid && prog_en) w_prog = 1'b1;
                else if (code_valid)            w_next = ST_IDLE;
                else if (w_tmr_done)            w_next = ST_IDLE;
            end
            ST_LOCKOUT: if (w_tmr_done) w_next = ST_IDLE;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Reprogramming restarts the open interval as if freshly unlocked.
    assign w_tmr_load = w_prog ||
        ((w_next != r_state) && ((w_next == ST_OPEN) || (w_next == ST_LOCKOUT)));
    assign w_tmr_val  = (w_next == ST_LOCKOUT) ? TMR_W'(LOCKOUT_CYC) : TMR_W'(OPEN_CYC);

    lock_timer #(.W(TMR_W)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_code       <= DEFAULT_CODE;
            r_shift      <= '0;
            r_idx        <= '0;
            r_mismatch   <= 1'b0;
            r_fail_cnt   <= '0;
            r_lock_n     <= 1'b1;
            r_buzz       <= 1'b0;
            r_busy       <= 1'b0;
            r_locked_out <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && code_valid) begin
                r_shift    <= code_in;
                r_mismatch <= 1'b0;
                r_idx      <= IDX_W'(CODE_W - 1);
            end else if (r_state == ST_CHECK) begin
                r_shift    <= {r_shift[CODE_W-2:0], 1'b0};
                r_mismatch <= w_mis_total;
                r_idx      <= r_idx - 1'b1;
            end
            if (w_prog) r_code <= code_in;
            // The count is bumped on entry to FAIL so FAIL can decide on the new value.
            if (r_state == ST_CHECK && w_next == ST_FAIL) begin
                if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + 1'b1;
            end else if ((w_next == ST_OPEN && r_state != ST_OPEN) ||
                         (r_state == ST_LOCKOUT && w_next == ST_IDLE)) begin
                r_fail_cnt <= '0;
            end
            r_lock_n     <= (w_next != ST_OPEN);
            r_buzz       <= (w_next == ST_FAIL) || (w_next == ST_LOCKOUT);
            r_busy       <= (w_next == ST_CHECK) || (w_next == ST_FAIL) || (w_next == ST_LOCKOUT);
            r_locked_out <= (w_next == ST_LOCKOUT);
        end
    end

    assign lock_n     = r_lock_n;
    assign buzz       = r_buzz;
    assign busy       = r_busy;
    assign locked_out = r_locked_out;
    assign fail_cnt   = r_fail_cnt;
    assign state      = r_state;

endmodule

// File: tb/tb_code_lock_fsm.sv
// Scoreboard bench for code_lock_fsm with default parameters.
module tb_code_lock_fsm;

    localparam int CODE_W      = 16;
    localparam int OPEN_CYC    = 32;
    localparam int LOCKOUT_CYC = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] code_in = '0;
    logic        code_valid = 1'b0;
    logic        prog_en = 1'b0;
    logic        relock = 1'b0;
    logic        lock_n, buzz, busy, locked_out;
    logic [3:0]  fail_cnt;
    logic [2:0]  state;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        bit exp_open;
        int exp_fail;
        bit exp_lockout;
    } exp_t;
    exp_t sb_q[$];

    code_lock_fsm dut (
        .clk        (clk),
        .rst        (rst),
        .code_in    (code_in),
        .code_valid (code_valid),
        .prog_en    (prog_en),
        .relock     (relock),
        .lock_n     (lock_n),
        .buzz       (buzz),
        .busy       (busy),
        .locked_out (locked_out),
        .fail_cnt   (fail_cnt),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic submit(input logic [15:0] code);
        code_in    = code;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_state"},      32'(state),      32'd0);
        check_val({tag, "_lock_n"},     32'(lock_n),     32'd1);
        check_val({tag, "_buzz"},       32'(buzz),       32'd0);
        check_val({tag, "_busy"},       32'(busy),       32'd0);
        check_val({tag, "_locked_out"}, 32'(locked_out), 32'd0);
        check_val({tag, "_fail_cnt"},   32'(fail_cnt),   32'd0);
    endtask

    task automatic attempt(input string tag, input logic [15:0] code,
                           input bit exp_open, input int exp_fail, input bit exp_lock);
        int   n;
        bit   hold_ok;
        exp_t e;
        sb_q.push_back('{exp_open, exp_fail, exp_lock});
        submit(code);
        n       = 0;
        hold_ok = 1'b1;
        while (state == 3'd1 && n < 100) begin
            hold_ok &= (busy == 1'b1) && (lock_n == 1'b1);
            n++;
            tick();
        end
        check_val({tag, "_check_cycles"}, 32'(n), 32'(CODE_W));
        check_val({tag, "_busy_locked"}, 32'(hold_ok), 32'd1);
        e = sb_q.pop_front();
        if (e.exp_open) begin
            check_val({tag, "_open_state"}, 32'(state),    32'd3);
            check_val({tag, "_lock_n"},     32'(lock_n),   32'd0);
            check_val({tag, "_fail_cnt"},   32'(fail_cnt), 32'd0);
        end else begin
            check_val({tag, "_fail_state"}, 32'(state),    32'd2);
            check_val({tag, "_buzz"},       32'(buzz),     32'd1);
            check_val({tag, "_lock_n"},     32'(lock_n),   32'd1);
            check_val({tag, "_fail_cnt"},   32'(fail_cnt), 32'(e.exp_fail));
            tick();
            check_val({tag, "_after_fail"}, 32'(state), e.exp_lockout ? 32'd4 : 32'd0);
            check_val({tag, "_after_buzz"}, 32'(buzz),  e.exp_lockout ? 32'd1 : 32'd0);
        end
    endtask

    task automatic wait_open_expire(input string tag);
        int n;
        n = 0;
        while (lock_n == 1'b0 && n < 200) begin
            n++;
            tick();
        end
        check_val({tag, "_open_cycles"}, 32'(n),     32'(OPEN_CYC));
        check_val({tag, "_relocked"},    32'(state), 32'd0);
    endtask

    initial begin
        int n;
        bit lo_ok;

        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        attempt("good", 16'd5938, 1'b1, 0, 1'b0);
        wait_open_expire("good");

        attempt("lsb_wrong", 16'd5939, 1'b0, 1, 1'b0);
        check_val("lsb_wrong_fail_cnt_hold", 32'(fail_cnt), 32'd1);

        attempt("good_clear", 16'd5938, 1'b1, 0, 1'b0);
        relock = 1'b1;
        tick();
        relock = 1'b0;
        check_val("relock_state", 32'(state), 32'd0);
        check_val("relock_lock_n", 32'(lock_n), 32'd1);

        attempt("wrong1", 16'd0,      1'b0, 1, 1'b0);
        attempt("wrong2", 16'hFFFF,   1'b0, 2, 1'b0);
        attempt("wrong3", 16'h9732,   1'b0, 3, 1'b1);

        n     = 0;
        lo_ok = 1'b1;
        while (locked_out == 1'b1 && n < 300) begin
            lo_ok &= (buzz == 1'b1) && (busy == 1'b1) && (lock_n == 1'b1);
            n++;
            if (n == 10) begin
                code_in    = 16'd5938;
                code_valid = 1'b1;
            end else begin
                code_valid = 1'b0;
            end
            tick();
        end
        code_valid = 1'b0;
        check_val("lockout_cycles",   32'(n),        32'(LOCKOUT_CYC));
        check_val("lockout_buzz",     32'(lo_ok),    32'd1);
        check_val("lockout_exit",     32'(state),    32'd0);
        check_val("lockout_fail_clr", 32'(fail_cnt), 32'd0);

        attempt("post_lockout", 16'd5938, 1'b1, 0, 1'b0);
        repeat (5) tick();
        code_in    = 16'hBEEF;
        code_valid = 1'b1;
        prog_en    = 1'b1;
        tick();
        code_valid = 1'b0;
        prog_en    = 1'b0;
        check_val("prog_stay_open", 32'(state), 32'd3);
        wait_open_expire("prog_reload");

        attempt("old_code", 16'd5938, 1'b0, 1, 1'b0);
        attempt("new_code", 16'hBEEF, 1'b1, 0, 1'b0);

        relock     = 1'b1;
        code_valid = 1'b1;
        prog_en    = 1'b1;
        code_in    = 16'h1234;
        tick();
        relock     = 1'b0;
        code_valid = 1'b0;
        prog_en    = 1'b0;
        check_val("relock_prio_state",  32'(state),  32'd0);
        check_val("relock_prio_lock_n", 32'(lock_n), 32'd1);

        attempt("code_kept", 16'hBEEF, 1'b1, 0, 1'b0);
        code_in    = 16'hBEEF;
        code_valid = 1'b1;
        tick();
        code_valid = 1'b0;
        check_val("plain_cv_exit", 32'(state), 32'd0);
        attempt("not_1234", 16'h1234, 1'b0, 1, 1'b0);

        submit(16'hBEEF);
        repeat (7) tick();
        check_val("mid_check_state", 32'(state), 32'd1);
        rst = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        #3;
        rst = 1'b1;
        tick();
        attempt("default_back", 16'd5938, 1'b1, 0, 1'b0);
        relock = 1'b1;
        tick();
        relock = 1'b0;
        attempt("beef_gone", 16'hBEEF, 1'b0, 1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/code_lock_fsm.md
Name: code_lock_fsm

Overview:
- Parametrised successor to the team's fixed 16-bit serial password lock FSM.
- Holds a programmable stored code of CODE_W bits and compares a submitted code bit-serially, MSB first, one bit per clock.
- Drives an active-low lock output and a buzzer; adds wrong-attempt counting, timed lockout, timed auto-relock and in-field code change.
- Sits between the keypad/code-entry front end and the door actuator/buzzer drivers.

Parameters:
- CODE_W, 16, width of the code in bits (2..32).
- DEFAULT_CODE, 16'd5938, stored code after reset (CODE_W bits wide).
- MAX_TRIES, 3, consecutive wrong attempts that trigger lockout (1..15).
- LOCKOUT_CYC, 64, lockout duration in clk cycles (>=1).
- OPEN_CYC, 32, unlocked duration before automatic relock (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- code_in  in  CODE_W  submitted code; sampled only when code_valid is accepted.
- code_valid  in  1  single-cycle submit strobe.
- prog_en  in  1  in OPEN: qualifies code_valid as "store new code".
- relock  in  1  in OPEN: immediate relock request.
- lock_n  out  1  0 = unlocked, 1 = locked.
- buzz  out  1  buzzer drive.
- busy  out  1  high when code_valid would be ignored (CHECK, FAIL, LOCKOUT).
- locked_out  out  1  high during LOCKOUT.
- fail_cnt  out  4  consecutive wrong attempts.
- state  out  3  current FSM state (debug).

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, lock_n=1, buzz=0, busy=0, locked_out=0, fail_cnt=0.
  - Stored code = DEFAULT_CODE; shift register, bit index and timers cleared.
  - Reset asserted in any state, including mid-CHECK, aborts the operation with no partial effect.
- State encoding (shared package): IDLE=0, CHECK=1, FAIL=2, OPEN=3, LOCKOUT=4.
- IDLE:
  - code_valid=1 -> capture code_in into the shift register, clear the mismatch flag, set the bit index to CODE_W-1, go to CHECK.
  - prog_en and relock are ignored.
- CHECK:
  - Each cycle, compare one captured bit against the stored-code bit at the current index (MSB first) and OR any inequality into the mismatch flag.
  - No early abort: every attempt spends exactly CODE_W cycles in CHECK.
  - After the index-0 bit, next state is OPEN if the mismatch flag (including this bit) is clear, else FAIL.
  - Result is visible CODE_W+1 cycles after the capture edge.
  - code_valid is ignored throughout.
- OPEN:
  - Entry: lock_n=0, fail_cnt cleared, open timer loaded with OPEN_CYC.
  - Leaves to IDLE (lock_n=1) when the timer expires (OPEN_CYC cycles), relock=1, or code_valid=1 with prog_en=0.
  - code_valid=1 with prog_en=1 -> stored code <= code_in; stay in OPEN and reload the timer.
  - Priority within one cycle: relock > program > plain code_valid > timer expiry.
- FAIL (one cycle):
  - buzz=1 for that cycle; fail_cnt increments, saturating at 15.
  - Incremented value >= MAX_TRIES -> LOCKOUT, else IDLE.
- LOCKOUT:
  - locked_out=1 and buzz=1 continuously for LOCKOUT_CYC cycles.
  - Then IDLE with fail_cnt=0. code_valid is ignored.
- busy=1 in CHECK, FAIL and LOCKOUT.
- lock_n=0 only in OPEN.
- All outputs are registered; no combinational input-to-output path.
- Timer widths: $clog2 of the larger of OPEN_CYC and LOCKOUT_CYC, plus 1.

Decomposition:
- Package code_lock_pkg holds the state enum/localparams, the fail_cnt width (4) and the DEFAULT_CODE constant.
- One natural sub-module, lock_timer: a loadable down-counter with a done pulse, shared by OPEN and LOCKOUT.

Test Plan:
- Reset, then code_in=5938 with one code_valid pulse -> busy for 16 cycles; lock_n=0 on cycle 17; lock_n returns to 1 after 32 cycles; fail_cnt=0 throughout.
- code_in=5939 (LSB wrong) -> still exactly 16 CHECK cycles; one-cycle buzz pulse; fail_cnt=1; lock_n stays 1.
- Three wrong codes -> third FAIL goes to LOCKOUT with locked_out=1 and buzz=1 for 64 cycles. code_valid=5938 during lockout is ignored. Afterwards fail_cnt=0 and 5938 unlocks.
- Unlock with 5938, then prog_en=1 and code_valid with code_in=0xBEEF -> stays OPEN and timer reloads. After relock, 5938 fails and 0xBEEF unlocks.
- Unlock, relock=1 together with code_valid+prog_en on the same cycle -> IDLE; stored code unchanged.
- Assert rst at CHECK cycle 8 -> all outputs at reset values immediately; stored code back to 5938.
